// File: rtl/dm_arbiter.sv
// Two-master arbiter sharing one single-cycle data-memory port.
// Each access is latched, issued to the memory for exactly one cycle
// (ISSUE), and read data is returned registered one cycle later with
// a one-cycle rvalid pulse to the master that issued it.
module dm_arbiter #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 32,
   parameter int PRIO_MODE = 0
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              m0_req,
   input  logic              m0_we,
   input  logic              m0_sel,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,

   input  logic              m1_req,
   input  logic              m1_we,
   input  logic              m1_sel,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,

   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   output logic              dm_we,
   output logic              dm_sel,
   input  logic [DATA_W-1:0] dm_rdata,

   output logic              busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   // Latched command and owner id (0 = m0, 1 = m1).
   logic                r_gid;
   logic                r_last;
   logic                r_we;
   logic                r_sel;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;

   // Read return registers.
   logic                r_rv0;
   logic                r_rv1;
   logic [DATA_W-1:0]   r_rd0;
   logic [DATA_W-1:0]   r_rd1;

   logic                w_issue;
   logic                w_elig0;
   logic                w_elig1;
   logic                w_any;
   logic                w_win;
   logic                w_cmd_we;
   logic                w_cmd_sel;
   logic [ADDR_W-1:0]   w_cmd_addr;
   logic [DATA_W-1:0]   w_cmd_wdata;

   // Eligibility masks the master being issued this cycle, then pick a winner.
   always_comb begin
      w_issue = (r_state == ISSUE);
      w_elig0 = m0_req & ~(w_issue & ~r_gid);
      w_elig1 = m1_req & ~(w_issue &  r_gid);
      w_any   = w_elig0 | w_elig1;
      w_win   = 1'b0;
      if (w_elig0 && w_elig1) begin
         if (PRIO_MODE == 1) begin
            w_win = 1'b0;
         end else begin
            w_win = ~r_last;
         end
      end else if (w_elig1) begin
         w_win = 1'b1;
      end
   end

   // Command mux for the selected winner.
   always_comb begin
      w_cmd_we    = m0_we;
      w_cmd_sel   = m0_sel;
      w_cmd_addr  = m0_addr;
      w_cmd_wdata = m0_wdata;
      if (w_win) begin
         w_cmd_we    = m1_we;
         w_cmd_sel   = m1_sel;
         w_cmd_addr  = m1_addr;
         w_cmd_wdata = m1_wdata;
      end
   end

   // Next-state: IDLE and ISSUE share the same rule, any eligible master issues.
   always_comb begin
      w_state_nxt = IDLE;
      if (w_any) begin
         w_state_nxt = ISSUE;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Latch the winning command; last_grant starts at m1 so m0 wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_gid   <= 1'b0;
         r_last  <= 1'b1;
         r_we    <= 1'b0;
         r_sel   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_any) begin
         r_gid   <= w_win;
         r_last  <= w_win;
         r_we    <= w_cmd_we;
         r_sel   <= w_cmd_sel;
         r_addr  <= w_cmd_addr;
         r_wdata <= w_cmd_wdata;
      end
   end

   // Capture read data at the closing edge of a read ISSUE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rv0 <= 1'b0;
         r_rv1 <= 1'b0;
         r_rd0 <= '0;
         r_rd1 <= '0;
      end else begin
         r_rv0 <= 1'b0;
         r_rv1 <= 1'b0;
         if (w_issue && !r_we) begin
            if (r_gid) begin
               r_rv1 <= 1'b1;
               r_rd1 <= dm_rdata;
            end else begin
               r_rv0 <= 1'b1;
               r_rd0 <= dm_rdata;
            end
         end
      end
   end

   // dm_we is gated by the state so an asynchronous reset kills a pending write at once.
   assign dm_we     = w_issue & r_we;
   assign dm_addr   = r_addr;
   assign dm_wdata  = r_wdata;
   assign dm_sel    = r_sel;
   assign busy      = w_issue;

   assign m0_gnt    = w_issue & ~r_gid;
   assign m1_gnt    = w_issue &  r_gid;
   assign m0_rvalid = r_rv0;
   assign m1_rvalid = r_rv1;
   assign m0_rdata  = r_rd0;
   assign m1_rdata  = r_rd1;

endmodule
